// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory signals of the load/store unit
interface load_store_unit_if;
  // pipeline request
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  // pipeline response
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  // data memory port
  logic [63:0] mem_address;
  logic [63:0] mem_WriteData;
  logic        mem_MemRead;
  logic        mem_MemWrite;
  logic [63:0] mem_Readdata;

  // the unit itself: accepts requests, initiates memory accesses
  modport master (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_Readdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_address, mem_WriteData, mem_MemRead, mem_MemWrite
  );

  // the surroundings: execute stage plus data memory
  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_Readdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_address, mem_WriteData, mem_MemRead, mem_MemWrite
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit with read-modify-write sub-dword stores
module load_store_unit #(
  parameter int WORD_IDX_W   = 15,
  parameter bit MISALIGN_ERR = 1'b1
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;

  // byte-address bits that matter: word index plus byte offset
  localparam int AW = WORD_IDX_W + 3;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] addr_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic          write_q;
  logic          err_q;
  logic [63:0]   wdata_q;
  logic [63:0]   merged_q;
  logic [63:0]   rdata_q;

  logic          misaligned;
  logic          go_err;
  logic          accept;
  logic [2:0]    low_mask;
  logic [AW-1:0] aligned_addr;
  logic          unused_addr_hi;

  // Upper address bits wrap around the memory and are deliberately dropped.
  assign unused_addr_hi = ^bus.req_addr[63:AW];

  // Replace the addressed lanes of the old dword with the low bits of the store data.
  function automatic logic [63:0] merge_lanes(input logic [63:0] old_dw, input logic [63:0] st_d,
                                              input logic [2:0] off, input logic [1:0] size);
    logic [63:0] m;
    logic [5:0]  sh;
    sh = {off, 3'b000};
    case (size)
      2'd0:    m = 64'h0000_0000_0000_00FF;
      2'd1:    m = 64'h0000_0000_0000_FFFF;
      2'd2:    m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return (old_dw & ~(m << sh)) | ((st_d & m) << sh);
  endfunction

  // Shift the addressed lane down and sign- or zero-extend it to 64 bits.
  function automatic logic [63:0] extract_lane(input logic [63:0] dw, input logic [2:0] off,
                                               input logic [1:0] size, input logic uns);
    logic [63:0] lane;
    lane = dw >> {off, 3'b000};
    case (size)
      2'd0:    return uns ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
      2'd1:    return uns ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      2'd2:    return uns ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: return lane;
    endcase
  endfunction

  // Request decode: alignment check; the aligned address doubles as the force-aligned one.
  always_comb begin
    low_mask     = 3'b111 << bus.req_size;
    misaligned   = |(bus.req_addr[2:0] & ~low_mask);
    go_err       = misaligned && MISALIGN_ERR;
    aligned_addr = {bus.req_addr[AW-1:3], bus.req_addr[2:0] & low_mask};
    accept       = (state == IDLE) && bus.req_valid;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and handshake/strobe outputs; strobes are suppressed while rst is high.
  always_comb begin
    state_nx         = state;
    bus.req_ready    = 1'b0;
    bus.resp_valid   = 1'b0;
    bus.mem_MemRead  = 1'b0;
    bus.mem_MemWrite = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (go_err)                                 state_nx = RESP;
          else if (bus.req_write && bus.req_size == 2'd3) state_nx = WRITE;
          else                                        state_nx = READ;
        end
      end
      READ: begin
        bus.mem_MemRead = !rst;
        state_nx        = write_q ? WRITE : RESP;
      end
      WRITE: begin
        bus.mem_MemWrite = !rst;
        state_nx         = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, merged write data and load result; held untouched through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      size_q   <= 2'd0;
      uns_q    <= 1'b0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= 64'd0;
      merged_q <= 64'd0;
      rdata_q  <= 64'd0;
    end else if (accept) begin
      addr_q  <= aligned_addr;
      size_q  <= bus.req_size;
      uns_q   <= bus.req_unsigned;
      write_q <= bus.req_write;
      err_q   <= go_err;
      wdata_q <= bus.req_wdata;
      rdata_q <= 64'd0;
      if (bus.req_write && bus.req_size == 2'd3 && !go_err) merged_q <= bus.req_wdata;
    end else if (state == READ) begin
      if (write_q) merged_q <= merge_lanes(bus.mem_Readdata, wdata_q, addr_q[2:0], size_q);
      else         rdata_q  <= extract_lane(bus.mem_Readdata, addr_q[2:0], size_q, uns_q);
    end
  end

  assign bus.resp_rdata    = rdata_q;
  assign bus.resp_err      = err_q;
  assign bus.mem_address   = {{(64-WORD_IDX_W){1'b0}}, addr_q[AW-1:3]};
  assign bus.mem_WriteData = merged_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit against a byte-array memory model
module tb_load_store_unit;
  localparam int W  = 8;
  localparam int NW = 1 << W;
  localparam int NB = NW * 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit #(.WORD_IDX_W(W), .MISALIGN_ERR(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // data memory seen by the DUT: combinational read, posedge write
  logic [63:0] mem [0:NW-1];
  assign bus.mem_Readdata = mem[bus.mem_address[W-1:0]];

  initial begin
    for (int w = 0; w < NW; w++) mem[w] = {$urandom, $urandom};
    forever begin
      @(posedge clk);
      if (bus.mem_MemWrite) mem[bus.mem_address[W-1:0]] <= bus.mem_WriteData;
    end
  end

  // reference model: plain byte-addressed memory
  logic [7:0] model [0:NB-1];

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [63:0] idx;
    logic [63:0] wdata;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp   = 0;
  int   n_fail  = 0;
  int   cycle   = 0;
  int   rr_mode = 2;
  bit   mon_en  = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
  endtask

  function automatic logic [63:0] model_load(input logic [63:0] a, input int sz, input bit uns);
    int          base;
    int          n;
    logic [63:0] v;
    base = int'(a % 64'(NB));
    n    = 1 << sz;
    v    = 64'd0;
    for (int i = 0; i < n; i++) v = v | (64'(model[base + i]) << (8 * i));
    if (n < 8 && !uns && v[8 * n - 1]) v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [63:0] a, input int sz, input logic [63:0] d);
    int base;
    base = int'(a % 64'(NB));
    for (int i = 0; i < (1 << sz); i++) model[base + i] = d[8 * i +: 8];
  endtask

  // consumer readiness: 0 random, 1 held low, 2 held high
  initial begin
    bus.resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       bus.resp_ready = ($urandom_range(0, 3) != 0);
        1:       bus.resp_ready = 1'b0;
        default: bus.resp_ready = 1'b1;
      endcase
    end
  end

  // Drive one request; on acceptance push the expected response (when tracked).
  task automatic issue(input bit wr, input int sz, input bit uns, input logic [63:0] a,
                       input logic [63:0] d, input bit track);
    exp_t e;
    bit   ok;
    bit   mis;
    @(posedge clk);
    #1;
    bus.req_write    = wr;
    bus.req_size     = 2'(sz);
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = d;
    bus.req_valid    = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 200 cycles");
      bus.req_valid = 1'b0;
      return;
    end
    if (track) begin
      mis     = (a % (64'd1 << sz)) != 64'd0;
      e.idx   = (a >> 3) % 64'(NW);
      e.acc   = cycle;
      e.rdata = 64'd0;
      e.err   = mis;
      e.wdata = 64'd0;
      if (mis) begin
        e.lat = 1; e.nrd = 0; e.nwr = 0;
      end else if (!wr) begin
        e.lat = 2; e.nrd = 1; e.nwr = 0;
        e.rdata = model_load(a, sz, uns);
      end else begin
        model_store(a, sz, d);
        e.wdata = model_load(a & ~64'd7, 3, 1'b1);
        if (sz == 3) begin e.lat = 2; e.nrd = 0; e.nwr = 1; end
        else         begin e.lat = 3; e.nrd = 1; e.nwr = 1; end
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 500 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: checks memory strobes and responses against the scoreboard head.
  initial begin
    bit prv;
    int nrd;
    int nwr;
    prv = 1'b0; nrd = 0; nwr = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || rst) begin
        prv = 1'b0; nrd = 0; nwr = 0;
      end else begin
        chk("strobe_exclusive", 64'(bus.mem_MemRead & bus.mem_MemWrite), 64'd0);
        if (bus.mem_MemRead || bus.mem_MemWrite) begin
          if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL strobe_without_request: got strobe expected none");
          end else begin
            if (bus.mem_MemRead)  nrd++;
            if (bus.mem_MemWrite) nwr++;
            chk("mem_address", bus.mem_address, sb[0].idx);
            if (bus.mem_MemWrite) chk("mem_WriteData", bus.mem_WriteData, sb[0].wdata);
          end
        end
        if (bus.req_ready) chk("idle_strobes", 64'({bus.mem_MemRead, bus.mem_MemWrite}), 64'd0);
        if (bus.resp_valid) begin
          if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL resp_without_request: got resp_valid=1 expected 0");
          end else begin
            if (!prv) begin
              chk("latency", 64'(cycle - sb[0].acc), 64'(sb[0].lat));
              chk("read_pulses", 64'(nrd), 64'(sb[0].nrd));
              chk("write_pulses", 64'(nwr), 64'(sb[0].nwr));
            end
            chk("resp_rdata", bus.resp_rdata, sb[0].rdata);
            chk("resp_err", 64'(bus.resp_err), 64'(sb[0].err));
            chk("req_ready_in_resp", 64'(bus.req_ready), 64'd0);
            chk("resp_strobes", 64'({bus.mem_MemRead, bus.mem_MemWrite}), 64'd0);
            if (bus.resp_ready) begin
              void'(sb.pop_front());
              nrd = 0; nwr = 0;
            end
          end
        end
        prv = bus.resp_valid && !bus.resp_ready;
      end
    end
  end

  // Watchdog.
  initial begin
    repeat (60000) @(posedge clk);
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: got no completion expected finish within 60000 cycles");
    summary();
    $finish;
  end

  // Main stimulus.
  initial begin
    logic [63:0] a;
    logic [63:0] d;
    int          sz;
    bit          wr;
    bit          uns;
    bit          seen;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 64'd0;
    bus.req_wdata    = 64'd0;
    #1;
    for (int w = 0; w < NW; w++)
      for (int b = 0; b < 8; b++) model[w * 8 + b] = mem[w][8 * b +: 8];

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
    chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
    chk("rst_strobes", 64'({bus.mem_MemRead, bus.mem_MemWrite}), 64'd0);
    chk("rst_mem_address", bus.mem_address, 64'd0);
    chk("rst_mem_WriteData", bus.mem_WriteData, 64'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // directed sequence
    issue(1'b1, 3, 1'b0, 64'h40, 64'h1122334455667788, 1'b1);
    issue(1'b0, 3, 1'b0, 64'h40, 64'd0, 1'b1);
    issue(1'b1, 0, 1'b0, 64'h43, 64'hAB, 1'b1);
    issue(1'b0, 0, 1'b0, 64'h43, 64'd0, 1'b1);
    issue(1'b0, 0, 1'b1, 64'h43, 64'd0, 1'b1);
    issue(1'b0, 1, 1'b0, 64'h45, 64'd0, 1'b1);
    drain();

    // consumer stalls for several cycles
    rr_mode = 1;
    issue(1'b0, 3, 1'b0, 64'h40, 64'd0, 1'b1);
    repeat (7) @(posedge clk);
    rr_mode = 2;
    drain();

    issue(1'b1, 2, 1'b0, 64'h104, 64'hDEADBEEF, 1'b1);
    issue(1'b0, 2, 1'b0, 64'h104, 64'd0, 1'b1);
    issue(1'b0, 3, 1'b1, 64'h100, 64'd0, 1'b1);
    drain();

    // reset in the WRITE cycle of a byte store
    mon_en = 1'b0;
    @(posedge clk);
    issue(1'b1, 0, 1'b0, 64'h201, 64'h5A, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.mem_MemRead) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rmw_read_seen", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_write_suppressed", 64'(bus.mem_MemWrite), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("post_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("post_rst_mem_word", mem[64'h201 >> 3], model_load(64'h200, 3, 1'b1));
    mon_en = 1'b1;

    // randomized traffic, addresses clustered and with random wrap-around high bits
    rr_mode = 0;
    for (int t = 0; t < 300; t++) begin
      wr  = 1'($urandom_range(0, 1));
      sz  = $urandom_range(0, 3);
      uns = 1'($urandom_range(0, 1));
      a   = {$urandom, $urandom};
      d   = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a[W+2:3] = W'($urandom_range(0, 15));
      if ($urandom_range(0, 4) != 0) a[2:0] = a[2:0] & (3'b111 << sz);
      issue(wr, sz, uns, a, d, 1'b1);
    end
    rr_mode = 2;
    drain();

    summary();
    $finish;
  end
endmodule
